vga_timing_controller: RTL

//  Sequences the VGA raster: one horizontal and one vertical axis counter,

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_fsm.sv | 65 ++++++
 rtl/vga_timing_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared encodings and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

    // Width of the horizontal and vertical counters and of pixel_x/pixel_y.
    localparam int CNT_W = 10;

    // Default 640x480@60 timing, in pixel clocks (h) and lines (v).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Phase of one raster axis.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Top-level sequencing state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: a wrapping counter with its ACTIVE/FRONT/SYNC/BACK phase
// tracked alongside. wrap flags the step that takes the count from its last
// value back to 0, so it can step the next axis up in the same cycle.
module vga_axis_fsm
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             step,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FP_START   = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] BP_START   = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] count_next;
    phase_t           phase_next;

    // The last count is never passed: it steps straight back to 0.
    assign wrap = step && (count == LAST);

    // Next count and phase; clear wins over step and parks the axis at 0.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_next = count;
        phase_next = phase;
        if (clear) begin
            count_next = '0;
            phase_next = PH_ACTIVE;
        end else if (step) begin
            count_next = wrap ? '0 : count + CNT_W'(1);
            case (phase)
                PH_ACTIVE: if (count_next == FP_START)   phase_next = PH_FRONT;
                PH_FRONT:  if (count_next == SYNC_START) phase_next = PH_SYNC;
                PH_SYNC:   if (count_next == BP_START)   phase_next = PH_BACK;
                PH_BACK:   if (wrap)                     phase_next = PH_ACTIVE;
            endcase
        end
    end

    // Count and phase registers.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            count <= count_next;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator. Two vga_axis_fsm instances form a lead
// counter running one cycle ahead of the outputs; every output is a register
// loaded from the lead position, so all of them line up with pixel_x/pixel_y.
// Build option: define VGA_FRAME_COUNT_EN to add the 16-bit frame_count port.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    input  logic             run,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pix_req,
    output logic             line_start,
    output logic             frame_start,
    output logic             busy
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);

    state_t           state, state_next;
    logic             lead_step, lead_clear;
    logic             h_wrap, v_wrap;
    logic [CNT_W-1:0] h_count, v_count;
    phase_t           h_phase, v_phase;
    logic             frame_end;   // outputs currently show the last pixel of a frame
    logic             next_active; // the pixel after the lead position is visible

    vga_axis_fsm #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .step      (lead_step),
        .clear     (lead_clear),
        .count     (h_count),
        .phase     (h_phase),
        .wrap      (h_wrap)
    );

    vga_axis_fsm #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .step      (h_wrap),
        .clear     (lead_clear),
        .count     (v_count),
        .phase     (v_phase),
        .wrap      (v_wrap)
    );

    // State register; frame_end follows the lead's frame wrap by one cycle,
    // which is exactly when the outputs sit on the last pixel of the frame.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state     <= ST_IDLE;
            frame_end <= 1'b0;
        end else begin
            state     <= state_next;
            frame_end <= v_wrap;
        end
    end

    // Start on run; stop only once the last pixel of a frame has been shown.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (run)                state_next = ST_RUN;
            ST_RUN:  if (frame_end && !run)  state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
        lead_step  = (state_next == ST_RUN);
        lead_clear = (state_next == ST_IDLE);
    end

    // Lead position L becomes the output position next cycle, so pix_req
    // there must say whether the pixel after L is visible.
    assign next_active = ((h_count < H_ACT_LAST) && (v_count < V_ACT_END)) ||
                         ((h_count == H_LAST) &&
                          ((v_count == V_LAST) || (v_count < V_ACT_LAST)));

    // Output registers: reset/idle values unless the next cycle is a RUN cycle.
    always_ff @(posedge clk_25MHz) begin
        if (reset || state_next != ST_RUN) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pix_req     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hsync       <= (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            pixel_x     <= h_count;
            pixel_y     <= v_count;
            pix_req     <= next_active;
            line_start  <= (h_count == '0);
            frame_start <= (h_count == '0) && (v_count == '0);
            busy        <= 1'b1;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Frame counter, stepping in the same cycle frame_start rises.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            frame_count <= '0;
        end else if (state_next == ST_RUN && h_count == '0 && v_count == '0) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
